// File: rtl/exec_muldiv_ctl_if.sv
// Execute <-> mul/div sequencer bundle: operation request and flush toward the sequencer,
// stall/busy/done status and the registered result back to execute.
interface exec_muldiv_ctl_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic             divzero_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  busy_o, stall_o, done_o, result_o, divzero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output busy_o, stall_o, done_o, result_o, divzero_o
    );
endinterface

// File: rtl/exec_muldiv_ctl.sv
// Iterative radix-2 MUL/MULHU/DIVU/MODU sequencer; WIDTH+1 cycles start-to-done (divide by zero: 1).
// No backpressure on the result: stall_o freezes execute while CALC runs or a start is being accepted.
module exec_muldiv_ctl #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    exec_muldiv_ctl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;
    logic [CNTW-1:0]    cnt;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nx;
    logic [WIDTH:0]     rem;
    logic [WIDTH:0]     rem_nx;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   quo_nx;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_trial;
    logic [WIDTH-1:0]   res_sel;
    logic               accept;
    logic               dz_start;
    logic               iterate;
    logic               last_iter;
    logic               stall;
    logic               busy_r;
    logic               done_r;
    logic               dz_r;
    logic [WIDTH-1:0]   res_r;

    // One datapath step; result selection looks at the post-step values so the
    // final iteration can load result_o on the same edge it leaves CALC.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        prod_nx   = {mul_sum, prod[WIDTH-1:1]};
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_trial = rem_shift - {1'b0, opb};
        if (!rem_trial[WIDTH]) begin
            rem_nx = rem_trial;
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = rem_shift;
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        case (op_q)
            2'b00:   res_sel = prod_nx[WIDTH-1:0];
            2'b01:   res_sel = prod_nx[2*WIDTH-1:WIDTH];
            2'b10:   res_sel = quo_nx;
            default: res_sel = rem_nx[WIDTH-1:0];
        endcase
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        dz_start  = 1'b0;
        iterate   = 1'b0;
        last_iter = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE, DONE: begin
                stall   = bus.start_i & ~bus.flush_i;
                state_d = IDLE;
                if (bus.start_i && !bus.flush_i) begin
                    accept = 1'b1;
                    if (bus.op_i[1] && (bus.b_i == '0)) begin
                        dz_start = 1'b1;
                        state_d  = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                stall = 1'b1;
                if (bus.flush_i) begin
                    state_d = IDLE;
                end else begin
                    iterate = 1'b1;
                    if (cnt == CNTW'(1)) begin
                        last_iter = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= 2'b00;
            opb    <= '0;
            prod   <= '0;
            rem    <= '0;
            quo    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            res_r  <= '0;
        end else begin
            state  <= state_d;
            busy_r <= (state_d == CALC);
            done_r <= (state_d == DONE);
            if (accept) begin
                op_q <= bus.op_i;
                opb  <= bus.b_i;
                cnt  <= CNTW'(WIDTH);
                prod <= {{WIDTH{1'b0}}, bus.a_i};
                rem  <= '0;
                quo  <= bus.a_i;
                dz_r <= dz_start;
                // Divide by zero follows the RISC-V convention: all-ones quotient, dividend remainder.
                if (dz_start) begin
                    res_r <= bus.op_i[0] ? bus.a_i : {WIDTH{1'b1}};
                end
            end else if (iterate) begin
                cnt <= cnt - CNTW'(1);
                if (op_q[1]) begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                end else begin
                    prod <= prod_nx;
                end
                if (last_iter) begin
                    res_r <= res_sel;
                end
            end
        end
    end

    assign bus.busy_o    = busy_r;
    assign bus.stall_o   = stall;
    assign bus.done_o    = done_r;
    assign bus.result_o  = res_r;
    assign bus.divzero_o = dz_r;

endmodule
